// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: func3 encodings of the M-extension ops and the
// state encoding of the multiply/divide sequencer.
package rv32m_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/udiv_iter.sv
// Unsigned restoring divider datapath: one quotient bit per step, a 5-bit
// counter from 31 down to 0 flags the final step via last.
module udiv_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quotient_next,
  output logic [31:0] remainder_next
);

  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic [4:0]  cnt;
  logic [32:0] shifted;
  logic [32:0] diff;

  // Next values are exposed so the owner can capture the final step's result
  // in the same edge that retires the operation.
  always_comb begin
    shifted        = {rem, quo[31]};
    diff           = shifted - {1'b0, dsr};
    quotient_next  = {quo[30:0], ~diff[32]};
    remainder_next = diff[32] ? shifted[31:0] : diff[31:0];
  end

  assign last = (cnt == 5'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
      cnt <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
      cnt <= 5'd31;
    end else if (step) begin
      quo <= quotient_next;
      rem <= remainder_next;
      cnt <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// RV32M execute-stage multiply/divide unit. Multiplies and degenerate divides
// retire through the MUL state in 2 cycles; normal divides iterate 32 cycles.
module rv32m_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  import rv32m_pkg::*;

  muldiv_state_t state;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  f3;
  logic        neg_q;
  logic        neg_r;
  logic        sp_zero;
  logic        sp_ovf;

  logic        accept;
  logic        in_signed;
  logic        in_zero;
  logic        in_ovf;
  logic        in_fast;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        div_load;
  logic        div_step;
  logic        div_last;
  logic [31:0] quo_next;
  logic [31:0] rem_next;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] fast_res;
  logic [31:0] div_res;

  // Request decode; flush always beats a same-cycle start.
  always_comb begin
    accept    = start && !flush && (state == ST_IDLE || state == ST_DONE);
    in_signed = !func3[0];
    in_zero   = (op2 == 32'd0);
    in_ovf    = in_signed && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
    in_fast   = !func3[2] || in_zero || in_ovf;
    mag1      = (in_signed && op1[31]) ? (32'd0 - op1) : op1;
    mag2      = (in_signed && op2[31]) ? (32'd0 - op2) : op2;
    div_load  = accept && !in_fast;
    div_step  = (state == ST_DIV);
  end

  // MULH/MULHSU treat op1 as signed, only MULH treats op2 as signed.
  always_comb begin
    a_ext = {{32{op_a[31] & (f3[1:0] != 2'b11)}}, op_a};
    b_ext = {{32{op_b[31] & (f3[1:0] == 2'b01)}}, op_b};
    prod  = a_ext * b_ext;
    if (f3[2]) begin
      if (sp_zero) fast_res = f3[1] ? op_a : 32'hFFFF_FFFF;
      else         fast_res = f3[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      fast_res = (f3[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end
    if (f3[1]) div_res = neg_r ? (32'd0 - rem_next) : rem_next;
    else       div_res = neg_q ? (32'd0 - quo_next) : quo_next;
  end

  udiv_iter u_udiv_iter (
    .clk            (clk),
    .rst            (rst),
    .load           (div_load),
    .step           (div_step),
    .dividend       (mag1),
    .divisor        (mag2),
    .last           (div_last),
    .quotient_next  (quo_next),
    .remainder_next (rem_next)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      f3      <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      sp_zero <= 1'b0;
      sp_ovf  <= 1'b0;
      result  <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            op_a    <= op1;
            op_b    <= op2;
            f3      <= func3;
            neg_q   <= in_signed && (op1[31] ^ op2[31]);
            neg_r   <= in_signed && op1[31];
            sp_zero <= in_zero;
            sp_ovf  <= in_ovf && !in_zero;
            state   <= in_fast ? ST_MUL : ST_DIV;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_MUL: begin
          result <= fast_res;
          state  <= ST_DONE;
        end
        ST_DIV: begin
          if (div_last) begin
            result <= div_res;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_MUL) || (state == ST_DIV);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Bench for rv32m_muldiv_unit: vector table plus random ops against a
// reference model, and hand sequences for flush, reset, ignored start and chaining.
module tb_rv32m_muldiv_unit;
  import rv32m_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  logic [31:0] exp_q[$];
  int          total;
  int          bad;
  logic [31:0] last_res;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  rv32m_muldiv_unit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func3  (func3),
    .op1    (op1),
    .op2    (op2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = int'(a);
    ib = int'(b);
    case (f)
      F3_MUL:    begin p = 64'(sa * sb); return p[31:0];  end
      F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      F3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      F3_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2] || b == 0) return 2;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 33;
  endfunction

  // ---------------- driver tasks ----------------
  // Called in cycle 0 (#1 after an edge); returns in cycle 1 with start low.
  task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input bit push);
    start = 1'b1;
    func3 = f;
    op1   = a;
    op2   = b;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called in cycle 1 of an op; returns during its done cycle (or at the bound).
  task automatic wait_done(input int lat, input string name);
    int cyc;
    logic [31:0] e;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " done"}, {31'd0, done}, 32'd1);
    check({name, " latency"}, cyc, lat);
    check({name, " busy_in_done"}, {31'd0, busy}, 32'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({name, " result"}, result, e);
      last_res = e;
    end else begin
      check({name, " queue_nonempty"}, 32'd0, 32'd1);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    drive_start(f, a, b, exp, 1'b1);
    check({name, " busy_c1"}, {31'd0, busy}, 32'd1);
    check({name, " done_c1"}, {31'd0, done}, 32'd0);
    wait_done(lat, name);
    @(posedge clk); #1;
    check({name, " done_pulse"}, {31'd0, done}, 32'd0);
    check({name, " result_hold"}, result, last_res);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int ndone;
    int first_done;
    logic [2:0]  rf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] e;

    total = 0;
    bad = 0;
    last_res = '0;
    rst = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    func3 = '0;
    op1 = '0;
    op2 = '0;

    vecs[0]  = '{F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
    vecs[1]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};
    vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
    vecs[4]  = '{F3_DIV,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 33};
    vecs[5]  = '{F3_REM,    32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 33};
    vecs[6]  = '{F3_DIVU,   32'd100,       32'd7,         32'd14,        33};
    vecs[7]  = '{F3_REMU,   32'd100,       32'd7,         32'd2,         33};
    vecs[8]  = '{F3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    vecs[9]  = '{F3_REMU,   32'd5,         32'd0,         32'd5,         2};
    vecs[10] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[11] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2};
    vecs[12] = '{F3_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
    vecs[13] = '{F3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[14] = '{F3_DIVU,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
    vecs[15] = '{F3_DIV,    32'h8000_0000, 32'd2,         32'hC000_0000, 33};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 24; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      if ($urandom_range(0, 7) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 30);
      run_op(rf, ra, rb, model(rf, ra, rb), model_lat(rf, ra, rb), $sformatf("rnd%0d", i));
    end

    // flush in cycle 10 of a divide, then a MUL started in cycle 11
    drive_start(F3_DIVU, 32'd1000, 32'd9, 32'd0, 1'b0);
    cyc = 1;
    while (cyc < 10) begin @(posedge clk); #1; cyc++; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    check("flush done", {31'd0, done}, 32'd0);
    check("flush result", result, last_res);
    run_op(F3_MUL, 32'd6, 32'd9, 32'd54, 2, "post_flush_mul");

    // flush and start together: start is dropped
    start = 1'b1; flush = 1'b1; func3 = F3_MUL; op1 = 32'd2; op2 = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("flush_start done", {31'd0, done}, 32'd0);

    // reset in the middle of a divide
    drive_start(F3_DIV, 32'd12345, 32'd67, 32'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst result", result, 32'd0);
    last_res = 32'd0;
    rst = 1'b1;
    run_op(F3_MULHU, 32'h0001_0000, 32'h0003_0000, 32'd3, 2, "post_rst_mulhu");

    // start pulses in cycles 5 and 20 of a divide are ignored
    drive_start(F3_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    cyc = 1; ndone = 0; first_done = 0;
    while (cyc < 40) begin
      start = (cyc == 5 || cyc == 20);
      func3 = F3_MUL; op1 = 32'd3; op2 = 32'd3;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first_done == 0) begin
          first_done = cyc;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ignored_start result", result, e);
            last_res = e;
          end
        end
      end
    end
    check("ignored_start done_count", ndone, 32'd1);
    check("ignored_start latency", first_done, 32'd33);
    check("ignored_start queue", exp_q.size(), 32'd0);

    // back-to-back: DIV, then MUL accepted in its done cycle, then DIV again
    drive_start(F3_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done(33, "chain0");
    drive_start(F3_MUL, 32'd11, 32'd13, 32'd143, 1'b1);
    check("chain1 busy_c1", {31'd0, busy}, 32'd1);
    wait_done(2, "chain1");
    drive_start(F3_DIVU, 32'd1000, 32'd10, 32'd100, 1'b1);
    check("chain2 busy_c1", {31'd0, busy}, 32'd1);
    wait_done(33, "chain2");
    @(posedge clk); #1;
    check("chain idle done", {31'd0, done}, 32'd0);
    check("chain result_hold", result, 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
